// File: rtl/cap_prop_sweep_monitor_if.sv
// Vector/result bundle between the sweep monitor and the property instances.
// master: the monitor, which drives vectors and samples ok bits.
// slave:  the property side, which consumes vectors and returns ok bits.
interface cap_prop_sweep_monitor_if #(
   parameter int XLEN  = 64,
   parameter int NPROP = 9
);
   logic [XLEN-1:0]  vec_base;
   logic [XLEN-1:0]  vec_len;
   logic [XLEN-1:0]  vec_addr;
   logic [XLEN-1:0]  vec_newBase;
   logic [XLEN-1:0]  vec_newLen;
   logic             vec_valid;
   logic [NPROP-1:0] prop_ok;

   modport master (
      output vec_base, vec_len, vec_addr, vec_newBase, vec_newLen, vec_valid,
      input  prop_ok
   );

   modport slave (
      input  vec_base, vec_len, vec_addr, vec_newBase, vec_newLen, vec_valid,
      output prop_ok
   );
endinterface

// File: rtl/cap_prop_sweep_monitor.sv
// Capability property sweep monitor: emits one stimulus vector per cycle
// (incremental walk or LFSR random), checks the returned ok bits against a
// mask, and keeps sticky failure status with a first-failure capture.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start
// LOAD   | one cycle: present vector 0, LFSR restarted from the seed
// RUN    | vector valid; check ok bits, load next vector or finish
// DONE   | run finished; status held until the next start
module cap_prop_sweep_monitor #(
   parameter int          XLEN  = 64,
   parameter int          NPROP = 9,
   parameter int          CNT_W = 32,
   parameter logic [63:0] SEED  = 64'hACE1_0000_0000_0001
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic                 mode,
   input  logic                 halt_on_fail,
   input  logic [CNT_W-1:0]     num_vectors,
   input  logic [NPROP-1:0]     prop_mask,
   cap_prop_sweep_monitor_if.master vif,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [NPROP-1:0]     fail_mask,
   output logic [CNT_W-1:0]     fail_index,
   output logic [XLEN-1:0]      fail_base,
   output logic [XLEN-1:0]      fail_len,
   output logic [XLEN-1:0]      fail_addr,
   output logic [CNT_W-1:0]     vec_count,
   output logic [CNT_W-1:0]     fail_count
);

   localparam logic [63:0] TAPS    = 64'hD800_0000_0000_0000;
   // A zero seed would lock the LFSR at zero forever.
   localparam logic [63:0] SEED_NZ = (SEED == 64'd0) ? 64'd1 : SEED;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   typedef struct packed {
      logic [XLEN-1:0] base;
      logic [XLEN-1:0] len;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] new_base;
      logic [XLEN-1:0] new_len;
   } vec_t;

   state_t           state;
   logic [63:0]      lfsr;
   logic             mode_q;
   logic             halt_q;
   logic [NPROP-1:0] mask_q;
   logic [CNT_W-1:0] remain;   // vectors still to present after the current one
   logic             vec_valid_q;
   vec_t             vec_q;

   vec_t             vec_next;
   logic [CNT_W-1:0] next_idx;
   logic [NPROP-1:0] bad;
   logic             stop;

   function automatic logic [63:0] lfsr_step(input logic [63:0] l);
      return (l >> 1) ^ (l[0] ? TAPS : 64'd0);
   endfunction

   function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

   function automatic vec_t gen_walk(input logic [CNT_W-1:0] idx);
      vec_t            v;
      logic [XLEN-1:0] i;
      i          = XLEN'(idx);
      v.base     = i;
      v.len      = i << 1;
      v.addr     = i + v.len;
      v.new_base = i + XLEN'(1);
      v.new_len  = v.len + XLEN'(1);
      return v;
   endfunction

   function automatic vec_t gen_rand(input logic [63:0] l);
      vec_t v;
      v.base     = XLEN'(l);
      v.len      = XLEN'(rotl(l, 17));
      v.addr     = XLEN'(rotl(l, 31));
      v.new_base = XLEN'(rotl(l, 43));
      v.new_len  = XLEN'(rotl(l, 53));
      return v;
   endfunction

   // Next vector: index 0 while in LOAD, otherwise the one after the current.
   always_comb begin
      next_idx = (state == S_LOAD) ? vec_count : vec_count + CNT_W'(1);
      vec_next = mode_q ? gen_walk(next_idx) : gen_rand(lfsr);
      bad      = ~vif.prop_ok & mask_q;
      stop     = (remain == '0) || ((|bad) && halt_q);
   end

   // Sequencer, counters and first-failure capture.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         lfsr        <= SEED_NZ;
         mode_q      <= 1'b0;
         halt_q      <= 1'b0;
         mask_q      <= '0;
         remain      <= '0;
         vec_valid_q <= 1'b0;
         vec_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fail        <= 1'b0;
         fail_mask   <= '0;
         fail_index  <= '0;
         fail_base   <= '0;
         fail_len    <= '0;
         fail_addr   <= '0;
         vec_count   <= '0;
         fail_count  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mode_q     <= mode;
                  halt_q     <= halt_on_fail;
                  mask_q     <= prop_mask;
                  remain     <= num_vectors - CNT_W'(1);
                  lfsr       <= SEED_NZ;
                  fail       <= 1'b0;
                  fail_mask  <= '0;
                  fail_index <= '0;
                  fail_base  <= '0;
                  fail_len   <= '0;
                  fail_addr  <= '0;
                  vec_count  <= '0;
                  fail_count <= '0;
                  if (num_vectors == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_LOAD;
                     done  <= 1'b0;
                  end
               end
            end
            S_LOAD: begin
               vec_q       <= vec_next;
               lfsr        <= lfsr_step(lfsr);
               vec_valid_q <= 1'b1;
               busy        <= 1'b1;
               state       <= S_RUN;
            end
            S_RUN: begin
               vec_count <= vec_count + CNT_W'(1);
               if (|bad) begin
                  if (fail_count != '1)
                     fail_count <= fail_count + CNT_W'(1);
                  if (!fail) begin
                     fail       <= 1'b1;
                     fail_mask  <= bad;
                     fail_index <= vec_count;
                     fail_base  <= vec_q.base;
                     fail_len   <= vec_q.len;
                     fail_addr  <= vec_q.addr;
                  end
               end
               if (stop) begin
                  vec_valid_q <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  vec_q  <= vec_next;
                  lfsr   <= lfsr_step(lfsr);
                  remain <= remain - CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign vif.vec_base    = vec_q.base;
   assign vif.vec_len     = vec_q.len;
   assign vif.vec_addr    = vec_q.addr;
   assign vif.vec_newBase = vec_q.new_base;
   assign vif.vec_newLen  = vec_q.new_len;
   assign vif.vec_valid   = vec_valid_q;

`ifdef FORMAL
   // Every presented vector must satisfy every checked property.
   always_ff @(posedge CLK) begin
      if (!RST && state == S_RUN)
         assert (!(|bad));
   end
`endif

endmodule

// File: tb/tb_cap_prop_sweep_monitor.sv
// Scoreboard bench for the capability property sweep monitor.
module tb_cap_prop_sweep_monitor;
   localparam int          XLEN  = 64;
   localparam int          NPROP = 9;
   localparam int          CNT_W = 32;
   localparam logic [63:0] SEED  = 64'hACE1_0000_0000_0001;
   localparam logic [63:0] TAPS  = 64'hD800_0000_0000_0000;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             start = 1'b0;
   logic             mode = 1'b0;
   logic             halt_on_fail = 1'b0;
   logic [CNT_W-1:0] num_vectors = '0;
   logic [NPROP-1:0] prop_mask = '1;
   logic             busy, done, fail;
   logic [NPROP-1:0] fail_mask;
   logic [CNT_W-1:0] fail_index, vec_count, fail_count;
   logic [XLEN-1:0]  fail_base, fail_len, fail_addr;

   logic             fault_en = 1'b0;
   logic [NPROP-1:0] ok_model;

   cap_prop_sweep_monitor_if #(.XLEN(XLEN), .NPROP(NPROP)) vif ();

   cap_prop_sweep_monitor #(.XLEN(XLEN), .NPROP(NPROP), .CNT_W(CNT_W), .SEED(SEED)) dut (
      .CLK(CLK), .RST(RST), .start(start), .mode(mode), .halt_on_fail(halt_on_fail),
      .num_vectors(num_vectors), .prop_mask(prop_mask), .vif(vif),
      .busy(busy), .done(done), .fail(fail), .fail_mask(fail_mask),
      .fail_index(fail_index), .fail_base(fail_base), .fail_len(fail_len),
      .fail_addr(fail_addr), .vec_count(vec_count), .fail_count(fail_count)
   );

   always #5 CLK = ~CLK;

   // Property-instance stand-in: bit 2 fails at base 5 and 7 when faults are on;
   // outside valid vectors the ok bits are all zero and must be ignored.
   always_comb begin
      ok_model = '1;
      if (fault_en && (vif.vec_base == 64'd5 || vif.vec_base == 64'd7))
         ok_model[2] = 1'b0;
      vif.prop_ok = vif.vec_valid ? ok_model : '0;
   end

   typedef struct packed {
      logic [63:0] b, l, a, nb, nl;
   } vexp_t;

   typedef struct packed {
      logic [63:0] f, m, idx, fb, fl, fa, vc, fc, bc;
   } sexp_t;

   vexp_t vq[$];
   sexp_t sq[$];
   vexp_t ve;
   sexp_t se;
   int    pass_cnt = 0;
   int    total_cnt = 0;
   int    busy_cyc = 0;
   logic  done_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

   task automatic push_walk(input int n);
      for (int i = 0; i < n; i++) begin
         logic [63:0] x;
         x = 64'(i);
         vq.push_back('{b: x, l: 2 * x, a: 3 * x, nb: x + 1, nl: 2 * x + 1});
      end
   endtask

   task automatic push_rand(input int n);
      logic [63:0] l;
      l = SEED;
      for (int i = 0; i < n; i++) begin
         vq.push_back('{b: l, l: rotl(l, 17), a: rotl(l, 31), nb: rotl(l, 43), nl: rotl(l, 53)});
         l = (l >> 1) ^ (l[0] ? TAPS : 64'd0);
      end
   endtask

   task automatic push_status(input logic [63:0] f, m, idx, fb, fl, fa, vc, fc, bc);
      sq.push_back('{f: f, m: m, idx: idx, fb: fb, fl: fl, fa: fa, vc: vc, fc: fc, bc: bc});
   endtask

   // Monitor: checks every presented vector and the status at each done rise.
   always @(negedge CLK) begin
      if (vif.vec_valid) begin
         if (vq.size() == 0) begin
            total_cnt++;
            $display("FAIL vec_unexpected: got vector base %0h, expected no vector", vif.vec_base);
         end else begin
            ve = vq.pop_front();
            check("vec_base", vif.vec_base, ve.b);
            check("vec_len", vif.vec_len, ve.l);
            check("vec_addr", vif.vec_addr, ve.a);
            check("vec_newBase", vif.vec_newBase, ve.nb);
            check("vec_newLen", vif.vec_newLen, ve.nl);
         end
      end
      if (busy) busy_cyc++;
      if (done && !done_prev) begin
         if (sq.size() == 0) begin
            total_cnt++;
            $display("FAIL status_unexpected: got done rise, expected none");
         end else begin
            se = sq.pop_front();
            check("fail", 64'(fail), se.f);
            check("fail_mask", 64'(fail_mask), se.m);
            check("fail_index", 64'(fail_index), se.idx);
            check("fail_base", fail_base, se.fb);
            check("fail_len", fail_len, se.fl);
            check("fail_addr", fail_addr, se.fa);
            check("vec_count", 64'(vec_count), se.vc);
            check("fail_count", 64'(fail_count), se.fc);
            check("busy_cycles", 64'(busy_cyc), se.bc);
         end
      end
      if (!busy && !done) busy_cyc = 0;
      done_prev = done;
   end

   task automatic run(input logic m, input logic h, input int n, input logic [NPROP-1:0] mask);
      int k;
      @(negedge CLK);
      mode = m; halt_on_fail = h; num_vectors = CNT_W'(n); prop_mask = mask; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (k = 0; k < 200 && !done; k++) @(negedge CLK);
      if (!done) begin
         total_cnt++;
         $display("FAIL run_timeout: got done=0 after %0d cycles, expected done=1", k);
      end
      @(negedge CLK);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (5) @(negedge CLK);
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_fail", 64'(fail), 0);
      check("rst_vec_valid", 64'(vif.vec_valid), 0);
      check("rst_vec_base", vif.vec_base, 0);
      check("rst_vec_len", vif.vec_len, 0);
      check("rst_vec_addr", vif.vec_addr, 0);
      check("rst_vec_newBase", vif.vec_newBase, 0);
      check("rst_vec_newLen", vif.vec_newLen, 0);
      check("rst_vec_count", 64'(vec_count), 0);

      // Clean walk of 4.
      push_walk(4);
      push_status(0, 0, 0, 0, 0, 0, 4, 0, 4);
      run(1'b1, 1'b0, 4, '1);

      // Walk of 10, failures at 5 and 7, no halt.
      fault_en = 1'b1;
      push_walk(10);
      push_status(1, 9'b000000100, 5, 5, 10, 15, 10, 2, 10);
      run(1'b1, 1'b0, 10, '1);

      // Same, halting at the first failure.
      push_walk(6);
      push_status(1, 9'b000000100, 5, 5, 10, 15, 6, 1, 6);
      run(1'b1, 1'b1, 10, '1);

      // Same failure, but bit 2 not checked.
      push_walk(10);
      push_status(0, 0, 0, 0, 0, 0, 10, 0, 10);
      run(1'b1, 1'b0, 10, 9'h1FB);
      fault_en = 1'b0;

      // Two random runs restart from the seed.
      push_rand(3);
      push_status(0, 0, 0, 0, 0, 0, 3, 0, 3);
      run(1'b0, 1'b0, 3, '1);
      push_rand(3);
      push_status(0, 0, 0, 0, 0, 0, 3, 0, 3);
      run(1'b0, 1'b0, 3, '1);

      // Reset in the middle of a 10-vector walk, at vector 2.
      push_walk(3);
      @(negedge CLK);
      mode = 1'b1; halt_on_fail = 1'b0; num_vectors = 10; prop_mask = '1; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (k = 0; k < 50 && !(vif.vec_valid && vif.vec_base == 64'd2); k++) @(negedge CLK);
      check("mid_reach_vec2", 64'(vif.vec_valid && vif.vec_base == 64'd2), 1);
      RST = 1'b1;
      @(negedge CLK);
      check("mid_rst_busy", 64'(busy), 0);
      check("mid_rst_vec_count", 64'(vec_count), 0);
      check("mid_rst_fail", 64'(fail), 0);
      check("mid_rst_vec_valid", 64'(vif.vec_valid), 0);
      RST = 1'b0;
      push_walk(3);
      push_status(0, 0, 0, 0, 0, 0, 3, 0, 3);
      run(1'b1, 1'b0, 3, '1);

      // Zero-length run from IDLE: done one cycle after start, no vectors.
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      push_status(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      mode = 1'b1; num_vectors = 0; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check("zero_done_1cyc", 64'(done), 1);
      repeat (5) @(negedge CLK);
      check("zero_vec_valid", 64'(vif.vec_valid), 0);

      check("vq_drained", 64'(vq.size()), 0);
      check("sq_drained", 64'(sq.size()), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/cap_prop_sweep_monitor.md
Name: cap_prop_sweep_monitor

Overview:
- Sequential stimulus generator and checker for the capability property modules (unique, exact, exactConditions, getBase, getTop, getLength, isInBounds, setAddr, …).
- Drives one vector per cycle to externally instantiated property instances and samples their ok bits.
- Keeps a sticky failure status, per-run counts and a first-failure capture.
- Sits in the simulation/FPGA self-test harness in place of per-property combinational assert wrappers.

Parameters:
XLEN, 64, width of base/len/addr/newBase/newLen vector fields
NPROP, 9, number of property ok inputs checked
CNT_W, 32, width of vector and failure counters
SEED, 64'hACE1_0000_0000_0001, LFSR reset/start seed (must be nonzero; zero is replaced by 1)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
start  in  1  pulse; begins a run when in IDLE or DONE
mode  in  1  0 = LFSR random, 1 = incremental walk; sampled on start
halt_on_fail  in  1  1 = stop at first failure; sampled on start
num_vectors  in  CNT_W  vectors per run; sampled on start
prop_mask  in  NPROP  1 = property checked; sampled on start
vec_base, vec_len, vec_addr, vec_newBase, vec_newLen  out  XLEN each  registered vector to property instances
vec_valid  out  1  vector outputs meaningful this cycle
prop_ok  in  NPROP  combinational results for the current vector
busy  out  1  in RUN
done  out  1  in DONE
fail  out  1  sticky: any masked failure this run
fail_mask  out  NPROP  failing bits of first failing vector
fail_index  out  CNT_W  index of first failing vector
fail_base, fail_len, fail_addr  out  XLEN each  capture of first failing vector
vec_count  out  CNT_W  vectors checked this run
fail_count  out  CNT_W  failing vectors this run (saturating)

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- Reset: state IDLE, LFSR=SEED, all outputs and counters 0.
- IDLE/DONE + start: latch mode, halt_on_fail, num_vectors, prop_mask. Clear fail, fail_*, vec_count, fail_count. Go to LOAD. If num_vectors==0, go directly to DONE with all counts 0.
- LOAD, one cycle: load the vec_* registers with vector index 0, set vec_valid=1, go to RUN. LFSR restarts from SEED every run.
- Vector generation, index i:
  - walk: base=i, len=i<<1, addr=i+len, newBase=i+1, newLen=len+1.
  - random: L = Galois LFSR, taps 64'hD800_0000_0000_0000, shifted right, advanced once per vector. base=L, len=rotl(L,17), addr=rotl(L,31), newBase=rotl(L,43), newLen=rotl(L,53).
  - All arithmetic modulo 2^XLEN. XLEN<64: LFSR remains 64 bits; fields take the low XLEN bits.
- RUN, each cycle:
  - bad = ~prop_ok & mask_latched.
  - vec_count increments every cycle.
  - If bad≠0: fail_count increments, saturating at all-ones. If fail was 0, capture fail_mask=bad, fail_index=vec_count, fail_base/len/addr = current vec_*, and set fail. Later failures never overwrite the capture.
  - Exit to DONE, with vec_valid=0 and the vec_* outputs held, when either:
    - the current vector is index num_vectors-1, or
    - bad≠0 and halt_on_fail.
  - Otherwise load the next vector. Throughput is one vector per cycle; latency from start to first vec_valid is 2 cycles.
- DONE holds all status until the next start or RST.
- start while busy (LOAD/RUN) is ignored.
- RST mid-run: returns to IDLE next edge with all outputs cleared; no partial status retained.
- prop_ok is ignored whenever vec_valid=0.
- Under FORMAL, assert !(|bad) in RUN each cycle.

Test Plan:
- Reset, then idle 5 cycles → busy=0, done=0, fail=0, all vec_*=0, vec_valid=0.
- Walk, num_vectors=4, prop_ok all-ones → vec_base sequence 0,1,2,3 and vec_len 0,2,4,6 on consecutive cycles. Then done=1, vec_count=4, fail=0; busy high exactly 4 cycles.
- Walk, num_vectors=10, prop_ok[2] forced 0 when vec_base==5 and 7, halt_on_fail=0:
  - fail=1, fail_mask=9'b000000100, fail_index=5, fail_base=5, fail_len=10, fail_addr=15.
  - fail_count=2, vec_count=10.
- Same stimulus with halt_on_fail=1 → done after vector 5, vec_count=6, fail_count=1.
- Same failure with prop_mask[2]=0 → fail=0, fail_count=0, vec_count=10.
- Random mode, two consecutive runs of 3 vectors → identical vec_base sequence in both runs; first vec_base=SEED. num_vectors=0 → done=1 one cycle after start, vec_valid never asserts.
- RST asserted at vector 2 of a 10-vector run → next cycle busy=0, vec_count=0, fail=0; a following start runs cleanly from index 0.
